// File: rtl/fifo_sync.sv
// -----------------------------------------------------------------------------
// fifo_sync
//   Single-clock show-ahead (first-word-fall-through) FIFO. The head word
//   is visible on q without a read request, so a consumer can inspect it
//   before deciding to pop.
//
// Handshake: a write is accepted on a rising clock edge when wrreq=1 and
//   (full=0 or rdreq=1). A read is accepted when rdreq=1 and empty=0.
//   Requests that are not accepted have no effect. There is no back-pressure
//   signal other than the full and empty flags.
//
// Ports:
//   clock  rising-edge clock
//   aclr   asynchronous active-high clear (pointers, count, flags)
//   data   write data, WIDTH bits
//   wrreq  write request
//   rdreq  read (pop) request
//   empty  registered, high when the FIFO holds 0 words
//   full   registered, high when the FIFO holds DEPTH words
//   q      head-of-queue word, 0 while empty
//   usedw  registered word count, 0..DEPTH
// -----------------------------------------------------------------------------
module fifo_sync #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic [WIDTH-1:0] data,
  input  logic             wrreq,
  input  logic             rdreq,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] q,
  output logic [AW:0]      usedw
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;
  logic [AW:0]      usedw_next;

  // A write while full is still legal when a pop frees the head slot in
  // the same edge; a read while empty is always dropped, so a simultaneous
  // request on an empty FIFO behaves as a plain write.
  assign wr_ok = wrreq && (!full || rdreq);
  assign rd_ok = rdreq && !empty;

  always_comb begin
    usedw_next = usedw;
    case ({wr_ok, rd_ok})
      2'b10:   usedw_next = usedw + (AW+1)'(1);
      2'b01:   usedw_next = usedw - (AW+1)'(1);
      default: usedw_next = usedw;
    endcase
  end

  // Storage is deliberately not cleared; stale words are hidden because q
  // is forced to zero while empty.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      storage[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      usedw <= usedw_next;
      // Flags come from the next count so they line up with usedw.
      empty <= (usedw_next == '0);
      full  <= (usedw_next == FULL_CNT);
    end
  end

  always_comb begin
    q = '0;
    if (!empty) begin
      q = storage[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fifo_sync.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync
//   Bench for fifo_sync: a WIDTH=15 instance and a WIDTH=1 instance sharing
//   clock and clear. Directed vector table, hand sequences for overflow,
//   full-with-simultaneous access and asynchronous clear, then random
//   traffic against queue-based reference models.
// -----------------------------------------------------------------------------
module tb_fifo_sync;

  localparam int W     = 15;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clock;
  logic aclr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic [W-1:0] data;
  logic         wrreq;
  logic         rdreq;
  logic         empty;
  logic         full;
  logic [W-1:0] q;
  logic [4:0]   usedw;

  logic         data1;
  logic         wrreq1;
  logic         rdreq1;
  logic         empty1;
  logic         full1;
  logic         q1;
  logic [4:0]   usedw1;

  fifo_sync #(.WIDTH(W), .DEPTH(DEPTH)) u_dut (
    .clock (clock),
    .aclr  (aclr),
    .data  (data),
    .wrreq (wrreq),
    .rdreq (rdreq),
    .empty (empty),
    .full  (full),
    .q     (q),
    .usedw (usedw)
  );

  fifo_sync #(.WIDTH(1), .DEPTH(DEPTH)) u_dut1 (
    .clock (clock),
    .aclr  (aclr),
    .data  (data1),
    .wrreq (wrreq1),
    .rdreq (rdreq1),
    .empty (empty1),
    .full  (full1),
    .q     (q1),
    .usedw (usedw1)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [0:0]   exp_q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [31:0] eq, input logic [31:0] eu,
                         input logic ee, input logic ef);
    chk({name, ".q"},     32'(q),     eq);
    chk({name, ".usedw"}, 32'(usedw), eu);
    chk({name, ".empty"}, 32'(empty), 32'(ee));
    chk({name, ".full"},  32'(full),  32'(ef));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [W-1:0] d);
    wrreq = wr;
    rdreq = rd;
    data  = d;
    tick();
    wrreq = 1'b0;
    rdreq = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         wr;
    logic         rd;
    logic [W-1:0] d;
    logic [W-1:0] exp_q;
    logic [4:0]   exp_used;
    logic         exp_empty;
    logic         exp_full;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // wr rd data  | q after edge, usedw, empty, full
    vecs[0]  = '{1'b1, 1'b0, 15'd3050, 15'd3050, 5'd1, 1'b0, 1'b0}; // show-ahead
    vecs[1]  = '{1'b0, 1'b1, 15'd0,    15'd0,    5'd0, 1'b1, 1'b0}; // pop to empty
    vecs[2]  = '{1'b1, 1'b0, 15'd100,  15'd100,  5'd1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 15'd200,  15'd100,  5'd2, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 15'd300,  15'd100,  5'd3, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 15'd0,    15'd200,  5'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 15'd0,    15'd300,  5'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 15'd0,    15'd0,    5'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 15'd0,    15'd0,    5'd0, 1'b1, 1'b0}; // underflow ignored
    vecs[9]  = '{1'b1, 1'b1, 15'd5,    15'd5,    5'd1, 1'b0, 1'b0}; // wr+rd on empty
    vecs[10] = '{1'b1, 1'b1, 15'd6,    15'd6,    5'd1, 1'b0, 1'b0}; // wr+rd on 1 word
    vecs[11] = '{1'b0, 1'b1, 15'd0,    15'd0,    5'd0, 1'b1, 1'b0};
  end

  // ---------------- main test ----------------
  initial begin
    int      n;
    logic    wr, rd, wr_ok, rd_ok;
    logic    wr1, rd1, wr_ok1, rd_ok1;
    logic [W-1:0] d;
    logic    d1;

    aclr   = 1'b1;
    data   = '0;
    wrreq  = 1'b0;
    rdreq  = 1'b0;
    data1  = 1'b0;
    wrreq1 = 1'b0;
    rdreq1 = 1'b0;
    tick();
    tick();

    // Reset state
    chk_all("reset", 0, 0, 1'b1, 1'b0);
    chk("reset.q1", 32'(q1), 0);
    chk("reset.empty1", 32'(empty1), 1);
    aclr = 1'b0;
    tick();

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].d);
      chk_all($sformatf("vec%0d", i), 32'(vecs[i].exp_q), 32'(vecs[i].exp_used),
              vecs[i].exp_empty, vecs[i].exp_full);
    end

    // Fill to full with 1..16
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, 1'b0, W'(i));
    end
    chk_all("filled", 1, 16, 1'b0, 1'b1);

    // Overflow write ignored
    drive(1'b1, 1'b0, 15'd99);
    chk_all("overflow", 1, 16, 1'b0, 1'b1);

    // Simultaneous on full: both execute, 77 goes to the tail
    drive(1'b1, 1'b1, 15'd77);
    chk_all("full_wr_rd", 2, 16, 1'b0, 1'b1);

    // Drain: expect 2..16 then 77 at the head before each pop
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d.q", i), 32'(q), (i < DEPTH - 1) ? 32'(i + 2) : 32'd77);
      drive(1'b0, 1'b1, '0);
    end
    chk_all("drained", 0, 0, 1'b1, 1'b0);

    // Asynchronous clear mid-operation with three words held
    drive(1'b1, 1'b0, 15'd10);
    drive(1'b1, 1'b0, 15'd20);
    drive(1'b1, 1'b0, 15'd30);
    chk_all("pre_clr", 10, 3, 1'b0, 1'b0);
    #2;
    aclr = 1'b1;
    #1;  // still well before the next rising edge
    chk_all("async_clr", 0, 0, 1'b1, 1'b0);
    tick();
    aclr = 1'b0;
    drive(1'b0, 1'b1, '0);
    chk_all("read_after_clr", 0, 0, 1'b1, 1'b0);

    // Random traffic on both instances against queue models
    exp_q.delete();
    exp_q1.delete();
    n = 0;
    for (int c = 0; c < 400; c++) begin
      // Alternate write-heavy and read-heavy phases to reach full and empty.
      if (((c / 50) % 2) == 0) begin
        wr  = ($urandom_range(0, 99) < 75);
        rd  = ($urandom_range(0, 99) < 35);
        wr1 = ($urandom_range(0, 99) < 75);
        rd1 = ($urandom_range(0, 99) < 35);
      end else begin
        wr  = ($urandom_range(0, 99) < 35);
        rd  = ($urandom_range(0, 99) < 75);
        wr1 = ($urandom_range(0, 99) < 35);
        rd1 = ($urandom_range(0, 99) < 75);
      end
      d  = W'($urandom_range(0, 32767));
      d1 = 1'($urandom_range(0, 1));

      wr_ok  = wr  && (exp_q.size()  < DEPTH || rd);
      rd_ok  = rd  && (exp_q.size()  > 0);
      wr_ok1 = wr1 && (exp_q1.size() < DEPTH || rd1);
      rd_ok1 = rd1 && (exp_q1.size() > 0);

      wrreq  = wr;   rdreq  = rd;   data  = d;
      wrreq1 = wr1;  rdreq1 = rd1;  data1 = d1;
      tick();

      if (rd_ok)  void'(exp_q.pop_front());
      if (wr_ok)  exp_q.push_back(d);
      if (rd_ok1) void'(exp_q1.pop_front());
      if (wr_ok1) exp_q1.push_back(d1);
      if (wr_ok1) n++;

      chk("rnd.q",     32'(q),     (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
      chk("rnd.usedw", 32'(usedw), 32'(exp_q.size()));
      chk("rnd.empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("rnd.full",  32'(full),  32'(exp_q.size() == DEPTH));
      chk("rnd1.q",     32'(q1),     (exp_q1.size() > 0) ? 32'(exp_q1[0]) : 32'd0);
      chk("rnd1.usedw", 32'(usedw1), 32'(exp_q1.size()));
      chk("rnd1.empty", 32'(empty1), 32'(exp_q1.size() == 0));
      chk("rnd1.full",  32'(full1),  32'(exp_q1.size() == DEPTH));
    end
    wrreq = 1'b0; rdreq = 1'b0; wrreq1 = 1'b0; rdreq1 = 1'b0;

    // The width-1 stream must have wrapped the pointers at least twice.
    chk("rnd1.wrap", 32'(n >= 2 * DEPTH), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
